// File: rtl/hs32_memory_pkg.sv
// HS32 shared pipeline types: stage packets, memory-op and memory-stage state enums.
package hs32_types;

  typedef enum logic [1:0] {
    MOP_NONE = 2'd0,
    MOP_LW   = 2'd1,
    MOP_SW   = 2'd2
  } mop_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    HOLD = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  rd;
    logic        we;
    logic [1:0]  mop;
    logic [31:0] sd;
  } hs32_s3pkt;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  rd;
    logic        we;
    logic        fault;
  } hs32_s4pkt;

  function automatic logic [31:0] word_addr(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/hs32_memory_if.sv
// HS32 data bus: single-word stb/ack transaction between memory stage and memory.
interface hs32_memory_if;

  logic        stb_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;

  modport master (
    output stb_o, we_o, addr_o, dat_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  stb_o, we_o, addr_o, dat_o,
    output dat_i, ack_i
  );

endinterface

// File: rtl/hs32_memory_tmo.sv
// HS32 memory-stage bus timeout counter (used only with HS32_MEM_TIMEOUT_EN).
module hs32_mem_tmo #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned W     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // fires in the LIMIT-th ack-less bus cycle so that op ends on that edge
  assign expired_o = en && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/hs32_memory.sv
// HS32 stage 4: memory access (LW/SW over stb/ack bus), pass-through otherwise.
// Optional bus timeout fault enabled by defining HS32_MEM_TIMEOUT_EN.
module hs32_memory
  import hs32_types::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_i,
  output logic          ready_o,
  input  hs32_s3pkt     data_i,
  output logic          valid_o,
  input  logic          ready_i,
  output hs32_s4pkt     data_o,
  output logic [3:0]    rd4_o,
  output logic          busy4_o,
  hs32_memory_if.master bus
);

  mem_state_e  state_q, state_d;
  logic        valid_q, valid_d;
  hs32_s4pkt   out_q, out_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sd_q, sd_d;
  logic [3:0]  rd_q, rd_d;
  logic        we_q, we_d;
  logic        lw_q, lw_d;

  logic accept;
  logic mem_in;
  logic tmo_exp;

  assign ready_o = (state_q == IDLE) && (!valid_q || ready_i);
  assign accept  = valid_i && ready_o;
  assign mem_in  = (data_i.mop == MOP_LW) || (data_i.mop == MOP_SW);

`ifdef HS32_MEM_TIMEOUT_EN
  localparam int unsigned TW_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned TW     = (TW_RAW < 8) ? 8 : TW_RAW;

  logic tmo_en;
  logic tmo_clr;

  assign tmo_en  = (state_q == BUS) && !bus.ack_i;
  assign tmo_clr = accept && mem_in;

  hs32_mem_tmo #(
    .LIMIT (TIMEOUT_CYC),
    .W     (TW)
  ) u_tmo (
    .clk       (clk),
    .reset     (reset),
    .en        (tmo_en),
    .clr       (tmo_clr),
    .expired_o (tmo_exp)
  );
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC != 0);
  assign tmo_exp    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q && !ready_i;
    out_d   = out_q;
    addr_d  = addr_q;
    sd_d    = sd_q;
    rd_d    = rd_q;
    we_d    = we_q;
    lw_d    = lw_q;
    unique case (state_q)
      IDLE: begin
        if (accept && mem_in) begin
          addr_d  = word_addr(data_i.res);
          sd_d    = data_i.sd;
          rd_d    = data_i.rd;
          we_d    = data_i.we;
          lw_d    = (data_i.mop == MOP_LW);
          state_d = BUS;
        end else if (accept) begin
          out_d.res   = data_i.res;
          out_d.rd    = data_i.rd;
          out_d.we    = data_i.we;
          out_d.fault = 1'b0;
          valid_d     = 1'b1;
        end
      end
      BUS: begin
        if (bus.ack_i) begin
          out_d.res   = lw_q ? bus.dat_i : addr_q;
          out_d.rd    = rd_q;
          out_d.we    = lw_q && we_q;
          out_d.fault = 1'b0;
          valid_d     = 1'b1;
          state_d     = IDLE;
        end else if (tmo_exp) begin
          out_d.res   = addr_q;
          out_d.rd    = rd_q;
          out_d.we    = 1'b0;
          out_d.fault = 1'b1;
          valid_d     = 1'b1;
          state_d     = ready_i ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (valid_q && ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      out_q   <= '0;
      addr_q  <= '0;
      sd_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      lw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      addr_q  <= addr_d;
      sd_q    <= sd_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      lw_q    <= lw_d;
    end
  end

  assign bus.stb_o  = (state_q == BUS);
  assign bus.we_o   = (state_q == BUS) && !lw_q;
  assign bus.addr_o = addr_q;
  assign bus.dat_o  = sd_q;

  assign valid_o = valid_q;
  assign data_o  = out_q;
  assign rd4_o   = (state_q == BUS) ? rd_q : out_q.rd;
  assign busy4_o = (state_q == BUS) && lw_q;

endmodule
